// File: rtl/sw_pkg.sv
// Shared types and defaults for the switch debouncer.
package sw_pkg;

  localparam int unsigned NumSwDefault          = 4;
  localparam int unsigned DebounceCyclesDefault = 16;

  typedef enum logic {
    STABLE,
    COUNTING
  } sw_state_e;

endpackage

// File: rtl/sw_debounce_chan.sv
// One debounce channel: 2-flop synchronizer, stability counter/FSM and edge pulses.
// Edge pulses are only built when SW_DEBOUNCE_EDGE_EN is defined; otherwise tied to 0.
module sw_debounce_chan
  import sw_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic sw_clean,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic            s1_q, s2_q;
  logic            clean_q, clean_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  sw_state_e       state_q, state_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      clean_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= STABLE;
    end else begin
      s1_q    <= sw;
      s2_q    <= s1_q;
      clean_q <= clean_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    clean_d = clean_q;
    unique case (state_q)
      STABLE: begin
        cnt_d = '0;
        if (s2_q != clean_q) state_d = COUNTING;
      end
      COUNTING: begin
        if (s2_q == clean_q) begin
          // Level bounced back before the window closed: drop the count.
          cnt_d   = '0;
          state_d = STABLE;
        end else if (cnt_q == CntMax) begin
          clean_d = s2_q;
          cnt_d   = '0;
          state_d = STABLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    endcase
  end

  assign sw_clean = clean_q;

`ifdef SW_DEBOUNCE_EDGE_EN
  logic rise_q, fall_q;

  // Registered from the same next-state as clean_q so pulses line up with the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= clean_d & ~clean_q;
      fall_q <= ~clean_d & clean_q;
    end
  end

  assign sw_rise = rise_q;
  assign sw_fall = fall_q;
`else
  assign sw_rise = 1'b0;
  assign sw_fall = 1'b0;
`endif

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer top; edge outputs compiled in by SW_DEBOUNCE_EDGE_EN.
// Channels are independent instances of sw_debounce_chan.
module sw_debounce
  import sw_pkg::*;
#(
  parameter int unsigned NUM_SW          = NumSwDefault,
  parameter int unsigned DEBOUNCE_CYCLES = DebounceCyclesDefault
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SW-1:0] sw,
  output logic [NUM_SW-1:0] sw_clean,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic              sw_changed
);

  for (genvar i = 0; i < NUM_SW; i++) begin : g_chan
    sw_debounce_chan #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .sw      (sw[i]),
      .sw_clean(sw_clean[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

`ifdef SW_DEBOUNCE_EDGE_EN
  assign sw_changed = |{sw_rise, sw_fall};
`else
  assign sw_changed = 1'b0;
`endif

endmodule

// File: tb/tb_sw_debounce.sv
// Self-checking bench for sw_debounce: vector table, directed corner cases and random
// stimulus against a streak-counting reference model.
module tb_sw_debounce;

  localparam int unsigned NSW = 4;
  localparam int unsigned DC  = 16;
`ifdef SW_DEBOUNCE_EDGE_EN
  localparam bit EdgeEn = 1'b1;
`else
  localparam bit EdgeEn = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst_n;
  logic [NSW-1:0] sw;
  logic [NSW-1:0] sw_clean, sw_rise, sw_fall;
  logic           sw_changed;

  always #5 clk = ~clk;

  sw_debounce #(
    .NUM_SW         (NSW),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .sw_clean  (sw_clean),
    .sw_rise   (sw_rise),
    .sw_fall   (sw_fall),
    .sw_changed(sw_changed)
  );

  int errors = 0;
  int checks = 0;

  // Reference: a level is accepted once DC+1 consecutive synchronized samples disagree
  // with the current clean level; synchronized sample = input seen two edges earlier.
  logic [NSW-1:0] m_d1, m_d2, m_clean, m_rise, m_fall;
  int             m_streak[NSW];

  task automatic model_reset();
    m_d1 = '0; m_d2 = '0; m_clean = '0; m_rise = '0; m_fall = '0;
    for (int i = 0; i < NSW; i++) m_streak[i] = 0;
  endtask

  task automatic model_step();
    logic [NSW-1:0] v;
    if (!rst_n) begin
      model_reset();
    end else begin
      v = m_d2;
      m_d2 = m_d1;
      m_d1 = sw;
      m_rise = '0;
      m_fall = '0;
      for (int i = 0; i < NSW; i++) begin
        if (v[i] != m_clean[i]) begin
          m_streak[i]++;
          if (m_streak[i] == DC + 1) begin
            m_clean[i] = v[i];
            if (v[i]) m_rise[i] = 1'b1;
            else m_fall[i] = 1'b1;
            m_streak[i] = 0;
          end
        end else begin
          m_streak[i] = 0;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic model_check();
    check("m_clean", 32'(sw_clean), 32'(m_clean));
    check("m_rise", 32'(sw_rise), EdgeEn ? 32'(m_rise) : 32'd0);
    check("m_fall", 32'(sw_fall), EdgeEn ? 32'(m_fall) : 32'd0);
    check("m_changed", 32'(sw_changed), EdgeEn ? 32'(|{m_rise, m_fall}) : 32'd0);
  endtask

  // Inputs change on the falling edge; the DUT and model both see them at the next rise.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  typedef struct {
    logic [NSW-1:0] sw;
    int             cycles;
    logic [NSW-1:0] exp_clean;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{4'b0000, 20, 4'b0000};
    tbl[1] = '{4'b0001, 18, 4'b0000};  // one edge short of acceptance
    tbl[2] = '{4'b0001, 1,  4'b0001};
    tbl[3] = '{4'b0011, 10, 4'b0001};  // ch1 glitch
    tbl[4] = '{4'b0000, 25, 4'b0000};
    tbl[5] = '{4'b1001, 19, 4'b1001};
    tbl[6] = '{4'b0000, 19, 4'b0000};

    rst_n = 1'b0;
    sw    = '0;
    model_reset();
    tick();
    tick();
    check("rst_clean", 32'(sw_clean), 32'd0);
    check("rst_pulses", 32'({sw_rise, sw_fall, sw_changed}), 32'd0);
    rst_n = 1'b1;

    for (int t = 0; t < 7; t++) begin
      sw = tbl[t].sw;
      repeat (tbl[t].cycles) tick();
      check($sformatf("tbl%0d_clean", t), 32'(sw_clean), 32'(tbl[t].exp_clean));
    end

    // Single rise: exact latency and one-cycle pulse.
    sw = 4'b0001;
    repeat (18) tick();
    check("rise0_early", 32'(sw_clean), 32'd0);
    tick();
    check("rise0_clean", 32'(sw_clean), 32'h1);
    check("rise0_pulse", 32'(sw_rise), EdgeEn ? 32'h1 : 32'h0);
    check("rise0_chg", 32'(sw_changed), EdgeEn ? 32'h1 : 32'h0);
    check("rise0_fall", 32'(sw_fall), 32'h0);
    tick();
    check("rise0_once", 32'({sw_rise, sw_changed}), 32'h0);
    sw = 4'b0000;
    repeat (22) tick();

    // Simultaneous fall on two channels.
    sw = 4'b1001;
    repeat (22) tick();
    sw = 4'b0000;
    repeat (18) tick();
    tick();
    check("fall_multi", 32'(sw_fall), EdgeEn ? 32'h9 : 32'h0);
    check("fall_chg", 32'(sw_changed), EdgeEn ? 32'h1 : 32'h0);
    repeat (3) tick();

    // ch2: 15 samples high, one low, then held high -> count restarts.
    sw = 4'b0100;
    repeat (15) tick();
    sw = 4'b0000;
    tick();
    sw = 4'b0100;
    repeat (18) tick();
    check("restart_early", 32'(sw_clean), 32'h0);
    tick();
    check("restart_clean", 32'(sw_clean), 32'h4);
    sw = 4'b0000;
    repeat (22) tick();

    // Reset mid-count, with a switch held through release.
    sw = 4'b1000;
    repeat (22) tick();
    sw = 4'b1001;
    repeat (10) tick();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("midrst_clean", 32'(sw_clean), 32'h0);
    check("midrst_pulses", 32'({sw_rise, sw_fall, sw_changed}), 32'h0);
    tick();
    tick();
    rst_n = 1'b1;
    repeat (18) tick();
    check("postrst_early", 32'(sw_clean), 32'h0);
    tick();
    check("postrst_clean", 32'(sw_clean), 32'h9);
    check("postrst_rise", 32'(sw_rise), EdgeEn ? 32'h9 : 32'h0);
    tick();
    check("postrst_once", 32'(sw_rise), 32'h0);

    // Random bouncing; mix of short glitches and long holds.
    repeat (3000) begin
      for (int i = 0; i < NSW; i++)
        if ($urandom_range(0, 19) == 0) sw[i] = ~sw[i];
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
